// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, reads instruction memory combinationally and
// registers the fetched word into the IF/ID pipeline register.
module instruction_fetch #(
  parameter int                    ADDR_WIDTH = 5,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_addr,
  input  logic [DATA_WIDTH-1:0] instruction,
  output logic [ADDR_WIDTH-1:0] instruction_address,
  output logic [DATA_WIDTH-1:0] if_instruction,
  output logic [ADDR_WIDTH-1:0] if_pc,
  output logic [ADDR_WIDTH-1:0] if_pc_next,
  output logic                  if_valid,
  output logic                  halted,
  output logic [15:0]           fetch_count
);

  typedef enum logic {S_RUN, S_HALT} state_t;

  localparam logic [5:0] HALT_OPCODE = 6'b111111;

  state_t                r_state, w_state;
  logic [ADDR_WIDTH-1:0] r_pc, w_pc;
  logic [DATA_WIDTH-1:0] r_if_instruction, w_if_instruction;
  logic [ADDR_WIDTH-1:0] r_if_pc, w_if_pc;
  logic [ADDR_WIDTH-1:0] r_if_pc_next, w_if_pc_next;
  logic                  r_if_valid, w_if_valid;
  logic [15:0]           r_fetch_count, w_fetch_count;
  logic [ADDR_WIDTH-1:0] w_pc_inc;
  logic                  w_is_halt;

  assign w_pc_inc  = r_pc + ADDR_WIDTH'(1);
  assign w_is_halt = (instruction[31:26] == HALT_OPCODE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= S_RUN;
      r_pc             <= RESET_PC;
      r_if_instruction <= '0;
      r_if_pc          <= '0;
      r_if_pc_next     <= '0;
      r_if_valid       <= 1'b0;
      r_fetch_count    <= '0;
    end else begin
      r_state          <= w_state;
      r_pc             <= w_pc;
      r_if_instruction <= w_if_instruction;
      r_if_pc          <= w_if_pc;
      r_if_pc_next     <= w_if_pc_next;
      r_if_valid       <= w_if_valid;
      r_fetch_count    <= w_fetch_count;
    end
  end

  always_comb begin
    w_state          = r_state;
    w_pc             = r_pc;
    w_if_instruction = r_if_instruction;
    w_if_pc          = r_if_pc;
    w_if_pc_next     = r_if_pc_next;
    w_if_valid       = r_if_valid;
    w_fetch_count    = r_fetch_count;
    case (r_state)
      S_RUN: begin
        if (redirect_valid) begin
          // Bubble squashes the wrong-path word; IF/ID data simply holds.
          w_pc       = redirect_addr;
          w_if_valid = 1'b0;
        end else if (stall) begin
          w_if_valid = r_if_valid;
        end else if (w_is_halt) begin
          w_state    = S_HALT;
          w_if_valid = 1'b0;
        end else begin
          w_if_instruction = instruction;
          w_if_pc          = r_pc;
          w_if_pc_next     = w_pc_inc;
          w_if_valid       = 1'b1;
          w_pc             = w_pc_inc;
          if (r_fetch_count != 16'hFFFF) w_fetch_count = r_fetch_count + 16'd1;
        end
      end
      S_HALT: begin
        // Only a redirect leaves HALT; stall has no effect here.
        w_if_valid = 1'b0;
        if (redirect_valid) begin
          w_pc    = redirect_addr;
          w_state = S_RUN;
        end
      end
      default: w_state = S_RUN;
    endcase
  end

  assign instruction_address = r_pc;
  assign if_instruction      = r_if_instruction;
  assign if_pc               = r_if_pc;
  assign if_pc_next          = r_if_pc_next;
  assign if_valid            = r_if_valid;
  assign halted              = (r_state == S_HALT);
  assign fetch_count         = r_fetch_count;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus randomized traffic,
// checked every cycle against a behavioural fetch model.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [4:0]  redirect_addr = '0;
  logic [31:0] instruction;
  logic [4:0]  instruction_address;
  logic [31:0] if_instruction;
  logic [4:0]  if_pc;
  logic [4:0]  if_pc_next;
  logic        if_valid;
  logic        halted;
  logic [15:0] fetch_count;

  logic [31:0] mem [32];
  assign instruction = mem[instruction_address];

  instruction_fetch #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .RESET_PC(5'd0)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_addr(redirect_addr), .instruction(instruction),
    .instruction_address(instruction_address), .if_instruction(if_instruction),
    .if_pc(if_pc), .if_pc_next(if_pc_next), .if_valid(if_valid),
    .halted(halted), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: PC as an integer mod 32, outputs as plain variables.
  int          m_pc = 0, m_ifpc = 0, m_ifpcn = 0, m_cnt = 0;
  logic [31:0] m_instr = '0;
  bit          m_valid = 1'b0, m_halted = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc <= 0; m_ifpc <= 0; m_ifpcn <= 0; m_cnt <= 0;
      m_instr <= '0; m_valid <= 1'b0; m_halted <= 1'b0;
    end else if (m_halted) begin
      m_valid <= 1'b0;
      if (redirect_valid) begin
        m_pc <= int'(redirect_addr);
        m_halted <= 1'b0;
      end
    end else if (redirect_valid) begin
      m_pc <= int'(redirect_addr);
      m_valid <= 1'b0;
    end else if (stall) begin
      m_valid <= m_valid;
    end else if (mem[m_pc][31:26] == 6'h3F) begin
      m_halted <= 1'b1;
      m_valid <= 1'b0;
    end else begin
      m_instr <= mem[m_pc];
      m_ifpc  <= m_pc;
      m_ifpcn <= (m_pc + 1) % 32;
      m_pc    <= (m_pc + 1) % 32;
      m_valid <= 1'b1;
      m_cnt   <= (m_cnt < 65535) ? m_cnt + 1 : m_cnt;
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("addr", instruction_address, m_pc);
      chk("valid", if_valid, m_valid);
      chk("halted", halted, m_halted);
      chk("count", fetch_count, m_cnt);
      if (m_valid) begin
        chk("if_instr", if_instruction, m_instr);
        chk("if_pc", if_pc, m_ifpc);
        chk("if_pc_next", if_pc_next, m_ifpcn);
      end
    end
  end

  task automatic chk_reset_values();
    chk("rst_addr", instruction_address, 0);
    chk("rst_instr", if_instruction, 0);
    chk("rst_pc", if_pc, 0);
    chk("rst_pc_next", if_pc_next, 0);
    chk("rst_valid", if_valid, 0);
    chk("rst_halted", halted, 0);
    chk("rst_count", fetch_count, 0);
  endtask

  task automatic load_seq_mem();
    for (int i = 0; i < 32; i++) mem[i] = 32'h1000_0000 + i;
  endtask

  initial begin
    load_seq_mem();
    #1 rst_n = 1'b0;
    #1 chk_reset_values();
    check_en = 1'b1;
    @(negedge clk) rst_n = 1'b1;

    // Sequential fetch with wrap
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk("first_pc", if_pc, 0);
        chk("first_valid", if_valid, 1);
      end
      if (k == 32) chk("wrap_pc_next", if_pc_next, 0);
      if (k == 33) chk("wrap_pc", if_pc, 0);
    end
    chk("seq_count", fetch_count, 40);
    chk("model_count", m_cnt, 40);
    chk("seq_pc", if_pc, 7);
    chk("seq_instr", if_instruction, 32'h1000_0007);

    // Stall at PC = 5
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_addr", instruction_address, 5);
      chk("stall_pc", if_pc, 4);
      chk("stall_valid", if_valid, 1);
      chk("stall_count", fetch_count, 5);
    end
    stall = 1'b0;
    @(negedge clk) chk("stall_release_pc", if_pc, 5);

    // Redirect with simultaneous stall at PC = 7
    @(negedge clk) chk("pre_redir_addr", instruction_address, 7);
    stall = 1'b1; redirect_valid = 1'b1; redirect_addr = 5'd20;
    @(negedge clk);
    chk("redir_addr", instruction_address, 20);
    chk("redir_bubble", if_valid, 0);
    stall = 1'b0; redirect_valid = 1'b0;
    @(negedge clk);
    chk("redir_pc", if_pc, 20);
    chk("redir_valid", if_valid, 1);
    chk("redir_instr", if_instruction, 32'h1000_0014);

    // Halt at address 10, then resume at 2
    mem[10] = 32'hFC00_0000;
    redirect_valid = 1'b1; redirect_addr = 5'd6;
    @(negedge clk) redirect_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_halt_pc", if_pc, 9);
    @(negedge clk);
    chk("halt_flag", halted, 1);
    chk("halt_valid", if_valid, 0);
    chk("halt_addr", instruction_address, 10);
    for (int k = 0; k < 10; k++) begin
      stall = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("halt_hold", halted, 1);
      chk("halt_hold_addr", instruction_address, 10);
    end
    stall = 1'b0; redirect_valid = 1'b1; redirect_addr = 5'd2;
    @(negedge clk) redirect_valid = 1'b0;
    chk("resume_halted", halted, 0);
    chk("resume_bubble", if_valid, 0);
    chk("resume_addr", instruction_address, 2);
    @(negedge clk);
    chk("resume_pc", if_pc, 2);
    chk("resume_valid", if_valid, 1);

    // Asynchronous reset while halted at PC = 13
    mem[10] = 32'h1000_000A;
    mem[13] = 32'hFFFF_FFFF;
    repeat (11) @(negedge clk);
    chk("halt13", halted, 1);
    chk("halt13_addr", instruction_address, 13);
    #2 rst_n = 1'b0;
    #1 chk_reset_values();
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_pc", if_pc, 0);
    chk("post_rst_valid", if_valid, 1);
    chk("post_rst_count", fetch_count, 1);
    mem[13] = 32'h1000_000D;

    // Randomized traffic with occasional halts and reset pulses
    for (int i = 0; i < 32; i++) begin
      mem[i] = $urandom;
      if ($urandom_range(0, 5) == 0) mem[i][31:26] = 6'h3F;
      else if (mem[i][31:26] == 6'h3F) mem[i][26] = 1'b0;
    end
    for (int k = 0; k < 600; k++) begin
      stall = ($urandom_range(0, 3) == 0);
      redirect_valid = ($urandom_range(0, 6) == 0);
      redirect_addr = 5'($urandom);
      if ($urandom_range(0, 96) == 0) begin
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
      @(negedge clk);
    end

    // fetch_count saturation
    stall = 1'b0; redirect_valid = 1'b0;
    load_seq_mem();
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    repeat (65540) @(negedge clk);
    chk("sat_count", fetch_count, 16'hFFFF);
    @(negedge clk) chk("sat_hold", fetch_count, 16'hFFFF);

    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
